// File: rtl/periph_bus.sv
// Memory-mapped peripheral block: timer (TH/TL/TCON), LED, switch and 7-segment registers.
// Optional free-running SYSTICK counter at offset 0x18 is built when PERIPH_BUS_SYSTICK_EN is defined.
module periph_bus #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irqout
);

  typedef enum logic [2:0] {
    REG_TH      = 3'd0,
    REG_TL      = 3'd1,
    REG_TCON    = 3'd2,
    REG_LED     = 3'd3,
    REG_SWITCH  = 3'd4,
    REG_DIGI    = 3'd5,
    REG_SYSTICK = 3'd6,
    REG_NONE    = 3'd7
  } reg_sel_t;

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [7:0]  led_reg;
  logic [11:0] digi_reg;
  logic [31:0] systick_val;

  logic [31:0] offset;
  reg_sel_t    sel;
  logic        we_th;
  logic        we_tl;
  logic        we_tcon;
  logic        we_led;
  logic        we_digi;
  logic        tl_max;
  logic        reload;
  logic        status_set;

  // Offset 0x1C lands on index 7, which doubles as the "unmapped" selector.
  always_comb begin
    offset = addr - BASE_ADDR;
    sel    = REG_NONE;
    if (offset[31:5] == '0 && offset[1:0] == 2'b00) begin
      sel = reg_sel_t'(offset[4:2]);
    end
  end

  always_comb begin
    we_th   = wr && (sel == REG_TH);
    we_tl   = wr && (sel == REG_TL);
    we_tcon = wr && (sel == REG_TCON);
    we_led  = wr && (sel == REG_LED);
    we_digi = wr && (sel == REG_DIGI);
  end

  // A software TL write suppresses the reload entirely, so it cannot raise status either.
  always_comb begin
    tl_max     = (tl == '1);
    reload     = tcon[0] && tl_max && !we_tl;
    status_set = reload && tcon[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th       <= '0;
      tl       <= '0;
      tcon     <= '0;
      led_reg  <= '0;
      digi_reg <= '0;
    end else begin
      if (we_th) begin
        th <= wdata;
      end
      if (we_tl) begin
        tl <= wdata;
      end else if (tcon[0]) begin
        tl <= tl_max ? th : tl + 32'd1;
      end
      if (we_tcon) begin
        tcon <= {wdata[2] | status_set, wdata[1:0]};
      end else if (status_set) begin
        tcon[2] <= 1'b1;
      end
      if (we_led) begin
        led_reg <= wdata[7:0];
      end
      if (we_digi) begin
        digi_reg <= wdata[11:0];
      end
    end
  end

`ifdef PERIPH_BUS_SYSTICK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      systick_val <= '0;
    end else begin
      systick_val <= systick_val + 32'd1;
    end
  end
`else
  assign systick_val = '0;
`endif

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (sel)
        REG_TH:      rdata = th;
        REG_TL:      rdata = tl;
        REG_TCON:    rdata = {29'd0, tcon};
        REG_LED:     rdata = {24'd0, led_reg};
        REG_SWITCH:  rdata = {24'd0, switch};
        REG_DIGI:    rdata = {20'd0, digi_reg};
        REG_SYSTICK: rdata = systick_val;
        default:     rdata = '0;
      endcase
    end
  end

  assign led    = led_reg;
  assign digi   = digi_reg;
  assign irqout = tcon[1] & tcon[2];

endmodule

// File: tb/tb_periph_bus.sv
// Directed bench for periph_bus: table of single-cycle bus vectors plus timer/reset sequences.
module tb_periph_bus;

  logic        clk;
  logic        reset;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  switch;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irqout;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] B = 32'h4000_0000;

  periph_bus #(.BASE_ADDR(B)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .switch(switch), .led(led), .digi(digi), .irqout(irqout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  sw;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_led;
    logic [11:0] exp_digi;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_cycle(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    rd = 1'b1; addr = a;
    #1;
    check(name, rdata, exp);
    rd = 1'b0;
  endtask

  initial begin
    logic [31:0] t0;
    logic [31:0] t1;
    rd = 0; wr = 0; addr = '0; wdata = '0; switch = 8'hA5; reset = 1'b1;
    idle(2);
    reset = 1'b0;

    vecs.push_back('{"rst_tcon",    1, 0, B+32'h08, 32'h0,         8'hA5, 32'h0,   8'h00, 12'h000, 0});
    vecs.push_back('{"rst_led",     1, 0, B+32'h0C, 32'h0,         8'hA5, 32'h0,   8'h00, 12'h000, 0});
    vecs.push_back('{"sw_read",     1, 0, B+32'h10, 32'h0,         8'hA5, 32'hA5,  8'h00, 12'h000, 0});
    vecs.push_back('{"sw_write",    0, 1, B+32'h10, 32'hFF,        8'hA5, 32'h0,   8'h00, 12'h000, 0});
    vecs.push_back('{"sw_reread",   1, 0, B+32'h10, 32'h0,         8'h3C, 32'h3C,  8'h00, 12'h000, 0});
    vecs.push_back('{"led_write",   0, 1, B+32'h0C, 32'h1234_5678, 8'hA5, 32'h0,   8'h78, 12'h000, 0});
    vecs.push_back('{"led_rdwr",    1, 1, B+32'h0C, 32'h0000_0011, 8'hA5, 32'h78,  8'h11, 12'h000, 0});
    vecs.push_back('{"digi_write",  0, 1, B+32'h14, 32'hFFFF_FABC, 8'hA5, 32'h0,   8'h11, 12'hABC, 0});
    vecs.push_back('{"digi_read",   1, 0, B+32'h14, 32'h0,         8'hA5, 32'hABC, 8'h11, 12'hABC, 0});
    vecs.push_back('{"rd_unalign",  1, 0, B+32'h0D, 32'h0,         8'hA5, 32'h0,   8'h11, 12'hABC, 0});
    vecs.push_back('{"wr_unalign",  0, 1, B+32'h0D, 32'hFF,        8'hA5, 32'h0,   8'h11, 12'hABC, 0});
    vecs.push_back('{"rd_outwin",   1, 0, 32'h5000_000C, 32'h0,    8'hA5, 32'h0,   8'h11, 12'hABC, 0});
    vecs.push_back('{"wr_below",    0, 1, B-32'h4, 32'hEE,         8'hA5, 32'h0,   8'h11, 12'hABC, 0});
    vecs.push_back('{"rd_past_map", 1, 0, B+32'h1C, 32'h0,         8'hA5, 32'h0,   8'h11, 12'hABC, 0});
    vecs.push_back('{"rd_disabled", 0, 0, B+32'h0C, 32'h0,         8'hA5, 32'h0,   8'h11, 12'hABC, 0});
    vecs.push_back('{"th_write",    0, 1, B+32'h00, 32'hDEAD,      8'hA5, 32'h0,   8'h11, 12'hABC, 0});
    vecs.push_back('{"th_read",     1, 0, B+32'h00, 32'h0,         8'hA5, 32'hDEAD,8'h11, 12'hABC, 0});
    vecs.push_back('{"wr_0x20",     0, 1, B+32'h20, 32'h55,        8'hA5, 32'h0,   8'h11, 12'hABC, 0});

    foreach (vecs[i]) begin
      rd = vecs[i].rd; wr = vecs[i].wr; addr = vecs[i].addr;
      wdata = vecs[i].wdata; switch = vecs[i].sw;
      #1;
      check({vecs[i].name, ".rdata"}, rdata, vecs[i].exp_rdata);
      @(posedge clk);
      #1;
      rd = 1'b0; wr = 1'b0; switch = 8'hA5;
      check({vecs[i].name, ".led"}, {24'd0, led}, {24'd0, vecs[i].exp_led});
      check({vecs[i].name, ".digi"}, {20'd0, digi}, {20'd0, vecs[i].exp_digi});
      check({vecs[i].name, ".irq"}, {31'd0, irqout}, {31'd0, vecs[i].exp_irq});
    end

    // Reload with interrupt
    wr_cycle(B+32'h00, 32'hFFFF_FFFC);
    wr_cycle(B+32'h04, 32'hFFFF_FFFE);
    wr_cycle(B+32'h08, 32'h3);
    rd_check("tl_start", B+32'h04, 32'hFFFF_FFFE);
    idle(1);
    rd_check("tl_max", B+32'h04, 32'hFFFF_FFFF);
    check("irq_before", {31'd0, irqout}, 32'd0);
    idle(1);
    rd_check("tl_reload", B+32'h04, 32'hFFFF_FFFC);
    rd_check("tcon_set", B+32'h08, 32'h7);
    check("irq_set", {31'd0, irqout}, 32'd1);

    // Clear status, then clear coinciding with reload
    wr_cycle(B+32'h08, 32'h3);
    check("irq_clear", {31'd0, irqout}, 32'd0);
    rd_check("tl_after_clear", B+32'h04, 32'hFFFF_FFFD);
    wr_cycle(B+32'h04, 32'hFFFF_FFFF);
    wr_cycle(B+32'h08, 32'h3);
    check("irq_hw_wins", {31'd0, irqout}, 32'd1);
    rd_check("tcon_hw_wins", B+32'h08, 32'h7);
    rd_check("tl_coinc_reload", B+32'h04, 32'hFFFF_FFFC);

    // TL write coinciding with reload
    wr_cycle(B+32'h08, 32'h3);
    wr_cycle(B+32'h04, 32'hFFFF_FFFF);
    wr_cycle(B+32'h04, 32'h5);
    rd_check("tl_sw_wins", B+32'h04, 32'h5);
    rd_check("tcon_unchanged", B+32'h08, 32'h3);
    check("irq_unchanged", {31'd0, irqout}, 32'd0);

    // TH write while running, then freeze
    wr_cycle(B+32'h00, 32'h100);
    rd_check("tl_th_write", B+32'h04, 32'h6);
    rd_check("th_new", B+32'h00, 32'h100);
    wr_cycle(B+32'h08, 32'h0);
    rd_check("tl_stop_edge", B+32'h04, 32'h7);
    idle(2);
    rd_check("tl_frozen", B+32'h04, 32'h7);

    // Reset mid-count with concurrent write
    wr_cycle(B+32'h08, 32'h3);
    reset = 1'b1; wr = 1'b1; addr = B+32'h0C; wdata = 32'hFF;
    @(posedge clk);
    #1;
    reset = 1'b0; wr = 1'b0;
    check("rst_led_out", {24'd0, led}, 32'd0);
    check("rst_digi_out", {20'd0, digi}, 32'd0);
    check("rst_irq_out", {31'd0, irqout}, 32'd0);
    rd_check("rst_tl", B+32'h04, 32'h0);
    rd_check("rst_th", B+32'h00, 32'h0);
    rd_check("rst_tcon", B+32'h08, 32'h0);
    idle(1);
    rd_check("rst_tl_idle", B+32'h04, 32'h0);

    // SYSTICK
    wr_cycle(B+32'h18, 32'h1234);
`ifdef PERIPH_BUS_SYSTICK_EN
    rd = 1'b1; addr = B+32'h18; #1; t0 = rdata; rd = 1'b0;
    idle(10);
    rd = 1'b1; addr = B+32'h18; #1; t1 = rdata; rd = 1'b0;
    check("systick_delta", t1 - t0, 32'd10);
`else
    t0 = 32'h0; t1 = 32'h0;
    rd_check("systick_absent", B+32'h18, t0 | t1);
    idle(10);
    rd_check("systick_absent2", B+32'h18, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
